// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between fetch and data access. Fixed data priority, or round robin with ARB_ROUND_ROBIN_EN.
// Latency: a request reaches m_req one cycle later. Completion strobes follow m_ready_n combinationally.
// Backpressure: each requester holds req until its ready_n strobe. A stalled grant is force-completed after TIMEOUT_CYCLES.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready_n,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready_n,
  output logic        d_busy,
  output logic        m_req,
  output logic        m_write,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready_n,
  output logic        err_timeout
);

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;

  state_t      state;
  logic [15:0] wait_cnt;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;
  logic        cmpl;
  logic        tmo;
  logic        fin;
  logic        req_i_m;
  logic        req_d_m;
  logic        win_i;
  logic        win_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_grant;  // 1 when data was served most recently
`endif

  // A real answer in the same cycle as the limit wins over the timeout.
  assign cmpl = (state != IDLE) && !m_ready_n;
  assign tmo  = (state != IDLE) && m_ready_n && (wait_cnt == TMO_LIMIT);
  assign fin  = cmpl || tmo;

  assign i_ready_n = !((state == GNT_I) && fin);
  assign d_ready_n = !((state == GNT_D) && fin);
  assign d_busy    = d_req && !((state == GNT_D) && fin);

  always_comb begin
    i_rdata = i_rdata_q;
    if ((state == GNT_I) && cmpl)     i_rdata = m_rdata;
    else if ((state == GNT_I) && tmo) i_rdata = NOP_INSTR;
  end

  always_comb begin
    d_rdata = d_rdata_q;
    if ((state == GNT_D) && cmpl)     d_rdata = m_rdata;
    else if ((state == GNT_D) && tmo) d_rdata = '0;
  end

  // The requester finishing now still holds req this cycle, so it is masked out.
  always_comb begin
    req_i_m = i_req && (state != GNT_I);
    req_d_m = d_req && (state != GNT_D);
    win_d   = req_d_m;
    win_i   = req_i_m && !req_d_m;
`ifdef ARB_ROUND_ROBIN_EN
    if (req_i_m && req_d_m) begin
      win_d = !last_grant;
      win_i = last_grant;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      m_req       <= 1'b0;
      m_write     <= 1'b0;
      m_size      <= 2'b00;
      m_addr      <= '0;
      m_wdata     <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      err_timeout <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant  <= 1'b0;
`endif
    end else begin
      if ((state == GNT_I) && fin) i_rdata_q <= i_rdata;
      if ((state == GNT_D) && fin) d_rdata_q <= d_rdata;
      if (tmo) begin
        err_timeout <= 1'b1;
        m_req       <= 1'b0;
        state       <= IDLE;
      end else if ((state == IDLE) || cmpl) begin
        wait_cnt <= '0;
        if (win_d) begin
          state   <= GNT_D;
          m_req   <= 1'b1;
          m_write <= d_write;
          m_size  <= d_size;
          m_addr  <= d_addr;
          m_wdata <= d_wdata;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant <= 1'b1;
`endif
        end else if (win_i) begin
          state   <= GNT_I;
          m_req   <= 1'b1;
          m_write <= 1'b0;
          m_size  <= 2'b10;
          m_addr  <= i_addr;
          m_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant <= 1'b0;
`endif
        end else begin
          state <= IDLE;
          m_req <= 1'b0;
        end
      end else begin
        wait_cnt <= wait_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: a transaction-level ownership model checked every cycle,
// plus directed scenarios for priority, timeout, async reset and back-to-back grants.
module tb_mem_bus_arbiter;

  localparam int          T   = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ready_n;
  logic        d_req = 1'b0;
  logic        d_write = 1'b0;
  logic [1:0]  d_size = 2'b00;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ready_n;
  logic        d_busy;
  logic        m_req;
  logic        m_write;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ready_n = 1'b1;
  logic        err_timeout;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(T), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready_n(i_ready_n),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready_n(d_ready_n), .d_busy(d_busy),
    .m_req(m_req), .m_write(m_write), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready_n(m_ready_n), .err_timeout(err_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus (0 none, 1 fetch, 2 data) and the command it issued.
  int          own, k, last;
  logic        err_m;
  logic [31:0] hold_i, hold_d;
  logic        c_write;
  logic [1:0]  c_size;
  logic [31:0] c_addr, c_wdata;
  int          glog[$];
  bit          i_done, d_done, done_prev;
  int          n_i_stb = 0;
  int          n_d_stb = 0;

  task automatic model_step();
    bit cmpl, tmo, fin;
    logic [31:0] e_ird, e_drd;
    bit pi, pd;
    int win;
    cmpl = (own != 0) && !m_ready_n;
    tmo  = (own != 0) && m_ready_n && (k == T);
    fin  = cmpl || tmo;
    e_ird = hold_i;
    if (own == 1 && cmpl) e_ird = m_rdata;
    else if (own == 1 && tmo) e_ird = NOP;
    e_drd = hold_d;
    if (own == 2 && cmpl) e_drd = m_rdata;
    else if (own == 2 && tmo) e_drd = 32'h0;
    check_val("m_req", 32'(m_req), 32'(own != 0));
    if (own != 0) begin
      check_val("m_addr", m_addr, c_addr);
      check_val("m_write", 32'(m_write), 32'(c_write));
      check_val("m_size", 32'(m_size), 32'(c_size));
      if (own == 2) check_val("m_wdata", m_wdata, c_wdata);
    end
    check_val("i_ready_n", 32'(i_ready_n), 32'(!(own == 1 && fin)));
    check_val("d_ready_n", 32'(d_ready_n), 32'(!(own == 2 && fin)));
    check_val("i_rdata", i_rdata, e_ird);
    check_val("d_rdata", d_rdata, e_drd);
    check_val("d_busy", 32'(d_busy), 32'(d_req && !(own == 2 && fin)));
    check_val("err_timeout", 32'(err_timeout), 32'(err_m));
    hold_i = e_ird;
    hold_d = e_drd;
    if (tmo) begin
      err_m = 1'b1;
      own   = 0;
    end else if (own == 0 || cmpl) begin
      pi  = i_req && (own != 1);
      pd  = d_req && (own != 2);
      win = pd ? 2 : (pi ? 1 : 0);
`ifdef ARB_ROUND_ROBIN_EN
      if (pi && pd) win = (last == 2) ? 1 : 2;
      if (win != 0) last = win;
`endif
      own = win;
      k   = 0;
      if (win == 2) begin
        c_write = d_write; c_size = d_size; c_addr = d_addr; c_wdata = d_wdata;
      end else if (win == 1) begin
        c_write = 1'b0; c_size = 2'b10; c_addr = i_addr;
      end
      if (win != 0) glog.push_back(win);
    end else begin
      k++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      own = 0; k = 0; last = 1; err_m = 1'b0; hold_i = '0; hold_d = '0;
    end else begin
      model_step();
    end
    i_done    = !i_ready_n;
    d_done    = !d_ready_n;
    done_prev = i_done || d_done;
    if (i_done) n_i_stb++;
    if (d_done) n_d_stb++;
  end

  // Stimulus knobs: mode 0 drops req after completion, 1 random, 2 continuous.
  int i_mode, d_mode, lat_mode;
  int mem_cnt, mem_lat;
  bit mreq_prev;

  task automatic tick();
    @(posedge clk);
    #1;
    if (m_req && (!mreq_prev || done_prev)) begin
      mem_cnt = 0;
      mem_lat = (lat_mode < 0) ? int'($urandom_range(0, 6)) : lat_mode;
    end else if (m_req) begin
      mem_cnt++;
    end
    mreq_prev = m_req;
    m_ready_n = !(m_req && mem_cnt == mem_lat);
    m_rdata   = $urandom;
    if (i_mode == 0) begin
      if (i_done) i_req = 1'b0;
    end else if (!i_req || i_done) begin
      i_req  = (i_mode == 2) || ($urandom_range(0, 1) == 1);
      i_addr = $urandom;
    end
    if (d_mode == 0) begin
      if (d_done) d_req = 1'b0;
    end else if (!d_req || d_done) begin
      d_req   = (d_mode == 2) || ($urandom_range(0, 1) == 1);
      d_write = 1'($urandom_range(0, 1));
      d_size  = 2'($urandom_range(0, 2));
      d_addr  = $urandom;
      d_wdata = $urandom;
    end
  endtask

  task automatic drain();
    int n = 0;
    i_mode = 0;
    d_mode = 0;
    do begin
      tick();
      n++;
    end while ((i_req || d_req || m_req) && n < 60);
    check_val("drain_idle", 32'(i_req || d_req || m_req), 32'h0);
  endtask

  function automatic int glog_at(input int i);
    return (i < glog.size()) ? glog[i] : -1;
  endfunction

  initial begin
    int base_g, base_i, base_d, idx;
    bit seen;
    i_mode = 0; d_mode = 0; lat_mode = -1;
    mem_cnt = 0; mem_lat = 0; mreq_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_m_req", 32'(m_req), 32'h0);
    check_val("rst_m_write", 32'(m_write), 32'h0);
    check_val("rst_m_size", 32'(m_size), 32'h0);
    check_val("rst_m_addr", m_addr, 32'h0);
    check_val("rst_m_wdata", m_wdata, 32'h0);
    check_val("rst_i_ready_n", 32'(i_ready_n), 32'h1);
    check_val("rst_d_ready_n", 32'(d_ready_n), 32'h1);
    check_val("rst_i_rdata", i_rdata, 32'h0);
    check_val("rst_d_rdata", d_rdata, 32'h0);
    check_val("rst_d_busy", 32'(d_busy), 32'h0);
    check_val("rst_err", 32'(err_timeout), 32'h0);
    rst = 1'b1;
    tick();

    // Single fetch, memory answers two cycles after m_req.
    lat_mode = 2;
    base_i = n_i_stb;
    tick();
    i_req = 1'b1; i_addr = 32'h0000_0100;
    tick();
    check_val("fetch_m_req", 32'(m_req), 32'h1);
    check_val("fetch_m_addr", m_addr, 32'h0000_0100);
    check_val("fetch_m_write", 32'(m_write), 32'h0);
    check_val("fetch_m_size", 32'(m_size), 32'h2);
    repeat (6) tick();
    check_val("fetch_strobes", 32'(n_i_stb - base_i), 32'h1);
    drain();

    // Simultaneous requests: data first, fetch granted on the data completion edge.
    base_g = glog.size();
    tick();
    i_req = 1'b1; i_addr = 32'h0000_0300;
    d_req = 1'b1; d_write = 1'b1; d_size = 2'b10; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF;
    tick();
    check_val("cont_m_write", 32'(m_write), 32'h1);
    check_val("cont_m_wdata", m_wdata, 32'hDEAD_BEEF);
    check_val("cont_m_addr", m_addr, 32'h0000_2000);
    repeat (10) tick();
    check_val("cont_first", 32'(glog_at(base_g)), 32'd2);
    check_val("cont_second", 32'(glog_at(base_g + 1)), 32'd1);
    drain();

    // Answer arrives exactly at the timeout limit: normal completion.
    lat_mode = T;
    base_d = n_d_stb;
    tick();
    d_req = 1'b1; d_write = 1'b0; d_size = 2'b01; d_addr = 32'h0000_0040;
    repeat (9) tick();
    check_val("edge_strobes", 32'(n_d_stb - base_d), 32'h1);
    check_val("edge_err", 32'(err_timeout), 32'h0);
    drain();

    // Fetch with a silent memory: forced completion with the NOP word.
    lat_mode = 99;
    tick();
    i_req = 1'b1; i_addr = 32'h0000_0500;
    idx = 0; seen = 1'b0;
    repeat (12) begin
      tick();
      @(negedge clk);
      if (!i_ready_n && !seen) begin
        seen = 1'b1;
        check_val("tmo_cycle", 32'(idx), 32'(T));
        check_val("tmo_nop", i_rdata, NOP);
      end
      if (m_req) idx++;
    end
    check_val("tmo_seen", 32'(seen), 32'h1);
    check_val("tmo_err", 32'(err_timeout), 32'h1);
    lat_mode = 1;
    drain();
    tick();
    d_req = 1'b1; d_write = 1'b1; d_size = 2'b00; d_addr = 32'h0000_0044; d_wdata = 32'h0000_00A5;
    repeat (5) tick();
    check_val("tmo_sticky", 32'(err_timeout), 32'h1);
    drain();

    // Asynchronous reset in the middle of a data grant.
    lat_mode = 99;
    base_d = n_d_stb;
    tick();
    d_req = 1'b1; d_write = 1'b0; d_size = 2'b10; d_addr = 32'h0000_0600;
    tick();
    tick();
    check_val("arst_pre_m_req", 32'(m_req), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check_val("arst_m_req", 32'(m_req), 32'h0);
    check_val("arst_d_ready_n", 32'(d_ready_n), 32'h1);
    check_val("arst_err", 32'(err_timeout), 32'h0);
    d_req = 1'b0;
    repeat (2) tick();
    check_val("arst_no_strobe", 32'(n_d_stb - base_d), 32'h0);
    rst = 1'b1;
    lat_mode = 2;
    tick();
    d_req = 1'b1; d_write = 1'b0; d_size = 2'b10; d_addr = 32'h0000_0700;
    repeat (6) tick();
    check_val("arst_after", 32'(n_d_stb - base_d), 32'h1);
    drain();

    // Both requesters continuously busy: accesses alternate D, I, D, I.
    base_g = glog.size();
    lat_mode = 1;
    i_mode = 2;
    d_mode = 2;
    repeat (16) tick();
    check_val("alt_g0", 32'(glog_at(base_g)), 32'd2);
    check_val("alt_g1", 32'(glog_at(base_g + 1)), 32'd1);
    check_val("alt_g2", 32'(glog_at(base_g + 2)), 32'd2);
    check_val("alt_g3", 32'(glog_at(base_g + 3)), 32'd1);
    drain();

    // Random traffic with random memory latency, including timeouts.
    lat_mode = -1;
    i_mode = 1;
    d_mode = 1;
    repeat (3000) tick();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
